// File: rtl/regfile_dump_reader.sv
// Register file dump reader.
// Walks the register file test read port from FIRST_REG to LAST_REG.
// Each 32-bit word is streamed as four bytes, MSB first, on a valid/ready
// byte interface. Every word is snapshotted at its LOAD edge, so later
// writes to that register do not reach the stream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; test_addr parked at FIRST_REG
// LOAD  | one cycle; capture test_data into shift_reg (bubble on stream)
// SEND  | present shift_reg[31:24]; shift by a byte on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  test_addr,
    input  logic [31:0] test_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    // An out-of-range window is a build mistake, not something to handle in logic
    if (FIRST_REG > LAST_REG || LAST_REG > 31 || FIRST_REG < 0) begin : g_cfg_err
        $error("regfile_dump_reader: bad register window FIRST_REG=%0d LAST_REG=%0d",
               FIRST_REG, LAST_REG);
    end

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  reg_idx;
    logic [4:0]  reg_idx_nxt;
    logic [1:0]  byte_cnt;
    logic [1:0]  byte_cnt_nxt;
    logic [31:0] shift_reg;
    logic [31:0] shift_reg_nxt;

    logic        at_last_reg;
    logic        at_last_byte;

    assign at_last_reg  = (reg_idx == LAST_IDX);
    assign at_last_byte = (byte_cnt == 2'd3);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            reg_idx   <= FIRST_IDX;
            byte_cnt  <= 2'd0;
            shift_reg <= 32'd0;
        end else begin
            state     <= state_nxt;
            reg_idx   <= reg_idx_nxt;
            byte_cnt  <= byte_cnt_nxt;
            shift_reg <= shift_reg_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt     = state;
        reg_idx_nxt   = reg_idx;
        byte_cnt_nxt  = byte_cnt;
        shift_reg_nxt = shift_reg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = LOAD;
                    reg_idx_nxt = FIRST_IDX;
                end
            end
            LOAD: begin
                shift_reg_nxt = test_data;
                byte_cnt_nxt  = 2'd0;
                state_nxt     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    shift_reg_nxt = {shift_reg[23:0], 8'd0};
                    byte_cnt_nxt  = byte_cnt + 2'd1;
                    if (at_last_byte) begin
                        if (at_last_reg) begin
                            state_nxt = DONE;
                        end else begin
                            reg_idx_nxt = reg_idx + 5'd1;
                            state_nxt   = LOAD;
                        end
                    end
                end
            end
            DONE: begin
                reg_idx_nxt = FIRST_IDX;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only; nothing flows through from test_data or out_ready
    always_comb begin
        out_valid = (state == SEND);
        out_data  = (state == SEND) ? shift_reg[31:24] : 8'd0;
        out_last  = (state == SEND) && at_last_byte && at_last_reg;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    assign test_addr = reg_idx;

endmodule
